guess_judge: RTL and testbench

Scoring stage of the 1A2B (Bulls and Cows) game, directly downstream of the random secret generator. Latches the generator's 16-bit secret (four distinct BCD digits) at game start and collects the player's four-digit guess one keypad digit at a time. It rejects guesses with repeated digits, scores each accepted guess sequentially into A (right digit, right place) and B (right digit, wrong place), and tracks attempts and win/lose.

---
 rtl/guess_judge_pkg.sv | 29 ++
 rtl/guess_judge_digit_match.sv | 31 +++
 rtl/guess_judge.sv | 155 +++++++++++++++
 tb/tb_guess_judge.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/guess_judge_pkg.sv
// Shared types and constants for the 1A2B guess judge.
package guess_judge_pkg;

    localparam int DIGIT_W           = 4;
    localparam int NUM_DIGITS        = 4;
    localparam int MAX_TRIES_DEFAULT = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_SCORE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // True when any two of the four nibbles of a guess are equal.
    function automatic logic has_dup(input logic [NUM_DIGITS*DIGIT_W-1:0] g);
        logic dup;
        dup = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            for (int j = i + 1; j < NUM_DIGITS; j++) begin
                if (g[i*DIGIT_W +: DIGIT_W] == g[j*DIGIT_W +: DIGIT_W]) begin
                    dup = 1'b1;
                end
            end
        end
        return dup;
    endfunction

endpackage

// File: rtl/guess_judge_digit_match.sv
// Classifies one guess nibble against the whole secret: same place (A),
// present elsewhere (B), or absent.
module digit_match
    import guess_judge_pkg::*;
(
    input  logic [DIGIT_W-1:0]            gnib,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] secret,
    input  logic [1:0]                    idx,
    output logic                          is_a,
    output logic                          is_b
);

    // Compare against every secret nibble; a positional hit takes precedence over B.
    always_comb begin
        is_a = 1'b0;
        is_b = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (secret[i*DIGIT_W +: DIGIT_W] == gnib) begin
                if (2'(i) == idx) begin
                    is_a = 1'b1;
                end else begin
                    is_b = 1'b1;
                end
            end
        end
        if (is_a) begin
            is_b = 1'b0;
        end
    end

endmodule

// File: rtl/guess_judge.sv
// 1A2B scoring stage: latches the secret, collects keypad digits, rejects
// guesses with repeated digits and scores accepted guesses one nibble per cycle.
module guess_judge
    import guess_judge_pkg::*;
#(
    parameter int MAX_TRIES = MAX_TRIES_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  nums,
    input  logic         new_game,
    input  logic         digit_valid,
    input  logic [3:0]   digit,
    input  logic         clr_entry,
    input  logic         submit,
    output logic [15:0]  guess,
    output logic [2:0]   entry_cnt,
    output logic [2:0]   a_cnt,
    output logic [2:0]   b_cnt,
    output logic         result_valid,
    output logic         err_dup,
    output logic [3:0]   attempts,
    output logic         win,
    output logic         game_over,
    output logic         busy
);

    localparam logic [3:0] MAX_T = 4'(MAX_TRIES);

    state_t       state;
    logic [15:0]  secret;
    logic [1:0]   idx;
    logic [2:0]   a_acc;
    logic [2:0]   b_acc;

    logic [DIGIT_W-1:0] cur_nib;
    logic               is_a;
    logic               is_b;
    logic [2:0]         a_fin;
    logic [2:0]         b_fin;
    logic [3:0]         attempts_nxt;

    // Nibble under evaluation this SCORE cycle.
    assign cur_nib = guess[{idx, 2'b00} +: DIGIT_W];

    digit_match u_match (
        .gnib   (cur_nib),
        .secret (secret),
        .idx    (idx),
        .is_a   (is_a),
        .is_b   (is_b)
    );

    // Running totals including the nibble scored this cycle, plus the saturated attempt count.
    always_comb begin
        a_fin        = a_acc + {2'b00, is_a};
        b_fin        = b_acc + {2'b00, is_b};
        attempts_nxt = (attempts == 4'hF) ? attempts : attempts + 4'd1;
    end

    assign busy = (state == ST_SCORE);

    // Game controller: entry, duplicate rejection, sequential scoring and win/lose tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            secret       <= '0;
            guess        <= '0;
            entry_cnt    <= '0;
            a_cnt        <= '0;
            b_cnt        <= '0;
            attempts     <= '0;
            idx          <= '0;
            a_acc        <= '0;
            b_acc        <= '0;
            result_valid <= 1'b0;
            err_dup      <= 1'b0;
            win          <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            err_dup      <= 1'b0;
            if (new_game) begin
                // A fresh game discards any partial entry or scoring in flight.
                secret    <= nums;
                guess     <= '0;
                entry_cnt <= '0;
                a_cnt     <= '0;
                b_cnt     <= '0;
                attempts  <= '0;
                win       <= 1'b0;
                game_over <= 1'b0;
                idx       <= '0;
                a_acc     <= '0;
                b_acc     <= '0;
                state     <= ST_ENTRY;
            end else begin
                case (state)
                    ST_IDLE: begin
                    end
                    ST_ENTRY: begin
                        if (clr_entry) begin
                            guess     <= '0;
                            entry_cnt <= '0;
                        end else if (digit_valid) begin
                            // A digit strobe masks a coincident submit even if the digit is dropped.
                            if (digit <= 4'd9 && entry_cnt < 3'd4) begin
                                guess     <= {guess[11:0], digit};
                                entry_cnt <= entry_cnt + 3'd1;
                            end
                        end else if (submit && entry_cnt == 3'd4) begin
                            if (has_dup(guess)) begin
                                err_dup   <= 1'b1;
                                guess     <= '0;
                                entry_cnt <= '0;
                            end else begin
                                idx   <= '0;
                                a_acc <= '0;
                                b_acc <= '0;
                                state <= ST_SCORE;
                            end
                        end
                    end
                    ST_SCORE: begin
                        a_acc <= a_fin;
                        b_acc <= b_fin;
                        if (idx == 2'd3) begin
                            a_cnt        <= a_fin;
                            b_cnt        <= b_fin;
                            result_valid <= 1'b1;
                            attempts     <= attempts_nxt;
                            if (a_fin == 3'd4) begin
                                win   <= 1'b1;
                                state <= ST_DONE;
                            end else if (attempts_nxt >= MAX_T) begin
                                game_over <= 1'b1;
                                state     <= ST_DONE;
                            end else begin
                                guess     <= '0;
                                entry_cnt <= '0;
                                state     <= ST_ENTRY;
                            end
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                    ST_DONE: begin
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_guess_judge.sv
// Directed bench for guess_judge with a scoreboard of expected A/B results.
module tb_guess_judge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] nums = '0;
    logic        new_game = 1'b0;
    logic        digit_valid = 1'b0;
    logic [3:0]  digit = '0;
    logic        clr_entry = 1'b0;
    logic        submit = 1'b0;
    logic [15:0] guess;
    logic [2:0]  entry_cnt;
    logic [2:0]  a_cnt;
    logic [2:0]  b_cnt;
    logic        result_valid;
    logic        err_dup;
    logic [3:0]  attempts;
    logic        win;
    logic        game_over;
    logic        busy;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
    } res_t;

    res_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    guess_judge #(.MAX_TRIES(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .nums         (nums),
        .new_game     (new_game),
        .digit_valid  (digit_valid),
        .digit        (digit),
        .clr_entry    (clr_entry),
        .submit       (submit),
        .guess        (guess),
        .entry_cnt    (entry_cnt),
        .a_cnt        (a_cnt),
        .b_cnt        (b_cnt),
        .result_valid (result_valid),
        .err_dup      (err_dup),
        .attempts     (attempts),
        .win          (win),
        .game_over    (game_over),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Reference scorer: A counts positional matches, B is shared digits minus A.
    function automatic res_t model(input logic [15:0] s, input logic [15:0] g);
        res_t r;
        int   a;
        int   common;
        a = 0;
        common = 0;
        for (int i = 0; i < 4; i++) begin
            if (s[i*4 +: 4] == g[i*4 +: 4]) a++;
            for (int j = 0; j < 4; j++) begin
                if (g[i*4 +: 4] == s[j*4 +: 4]) common++;
            end
        end
        r.a = 3'(a);
        r.b = 3'(common - a);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        digit_valid = 1'b1;
        digit = d;
        tick();
        digit_valid = 1'b0;
        digit = '0;
    endtask

    // Leftmost digit first, so it ends up in nibble 3.
    task automatic enter4(input logic [15:0] g);
        for (int i = 3; i >= 0; i--) press(g[i*4 +: 4]);
    endtask

    task automatic do_submit();
        submit = 1'b1;
        tick();
        submit = 1'b0;
    endtask

    task automatic start_game(input logic [15:0] s);
        nums = s;
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        nums = 16'h0F0F;
    endtask

    // Wait (bounded) for result_valid, check its latency and the scoreboard entry.
    task automatic wait_result(input string tag);
        int   got;
        res_t e;
        got = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (result_valid) begin
                got = k;
                break;
            end
        end
        check({tag, "_latency"}, got, 4);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_a"}, {29'd0, a_cnt}, {29'd0, e.a});
            check({tag, "_b"}, {29'd0, b_cnt}, {29'd0, e.b});
        end
    endtask

    task automatic score_guess(input logic [15:0] s, input logic [15:0] g, input string tag);
        enter4(g);
        exp_q.push_back(model(s, g));
        do_submit();
        wait_result(tag);
    endtask

    // Count result_valid and err_dup pulses over a window.
    task automatic quiet(input int n, output int rv, output int ed);
        rv = 0;
        ed = 0;
        for (int k = 0; k < n; k++) begin
            if (result_valid) rv++;
            if (err_dup) ed++;
            tick();
        end
    endtask

    initial begin
        int rv;
        int ed;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_guess", guess, 0);
        check("rst_entry", entry_cnt, 0);
        check("rst_ab", {a_cnt, b_cnt}, 0);
        check("rst_flags", {result_valid, err_dup, win, game_over, busy}, 0);
        check("rst_attempts", attempts, 0);
        press(4'd5);
        check("idle_digit_ignored", entry_cnt, 0);

        // Immediate win
        start_game(16'h8763);
        check("ng_entry", entry_cnt, 0);
        enter4(16'h8763);
        check("entry_guess", guess, 16'h8763);
        check("entry_cnt4", entry_cnt, 4);
        exp_q.push_back(model(16'h8763, 16'h8763));
        do_submit();
        check("busy_score", busy, 1);
        wait_result("win");
        check("win_flag", win, 1);
        check("win_attempts", attempts, 1);
        tick();
        check("rv_pulse", result_valid, 0);
        do_submit();
        quiet(8, rv, ed);
        check("done_submit_ignored", rv, 0);
        check("done_busy", busy, 0);
        check("done_hold", {win, attempts}, {1'b1, 4'd1});

        // Mixed results
        start_game(16'h8763);
        check("ng_clear", {win, attempts, a_cnt, b_cnt}, 0);
        score_guess(16'h8763, 16'h3678, "g3678");
        score_guess(16'h8763, 16'h1234, "g1234");
        score_guess(16'h8763, 16'h8673, "g8673");
        check("three_attempts", attempts, 3);
        check("three_nowin", win, 0);

        // Duplicate rejection
        enter4(16'h1123);
        do_submit();
        check("dup_pulse", err_dup, 1);
        check("dup_entry_clr", entry_cnt, 0);
        tick();
        check("dup_pulse_end", err_dup, 0);
        check("dup_attempts", attempts, 3);

        // Short submit, out-of-range digit, fifth digit, clear with digit
        press(4'd1);
        press(4'd2);
        press(4'd3);
        do_submit();
        quiet(6, rv, ed);
        check("short_submit", {rv[7:0], ed[7:0]}, 0);
        check("short_cnt", entry_cnt, 3);
        press(4'd12);
        check("digit12_ignored", entry_cnt, 3);
        press(4'd4);
        press(4'd5);
        check("fifth_ignored", {13'd0, entry_cnt, guess}, {13'd0, 3'd4, 16'h1234});
        clr_entry = 1'b1;
        digit_valid = 1'b1;
        digit = 4'd7;
        tick();
        clr_entry = 1'b0;
        digit_valid = 1'b0;
        check("clr_wins", {13'd0, entry_cnt, guess}, 0);

        // Run out of attempts
        start_game(16'h8763);
        for (int t = 1; t <= 10; t++) begin
            score_guess(16'h8763, 16'h1245, "lose");
            if (t == 9) check("go_before_last", game_over, 0);
        end
        check("game_over", game_over, 1);
        check("go_attempts", attempts, 10);
        start_game(16'h5120);
        check("ng_clears_go", {game_over, attempts}, 0);

        // new_game aborting a score in progress
        enter4(16'h1234);
        do_submit();
        tick();
        start_game(16'h1234);
        quiet(6, rv, ed);
        check("abort_no_result", rv, 0);
        check("abort_state", {busy, entry_cnt}, 0);
        score_guess(16'h1234, 16'h1234, "reload");
        check("reload_win", win, 1);

        // Reset while scoring
        start_game(16'h8763);
        enter4(16'h1234);
        do_submit();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_outputs", {guess, 1'b0, entry_cnt, a_cnt, b_cnt, attempts, result_valid, err_dup, win, game_over, busy}, 0);
        quiet(6, rv, ed);
        check("rst2_no_result", rv, 0);
        press(4'd3);
        check("rst2_idle", entry_cnt, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
